// File: rtl/exception_beta_pkg.sv
// Shared types and constants for the exception_beta arbiter: cause bit indices,
// ExcCode values, vector offsets and the handshake FSM state encoding.
`default_nettype none

package exception_pkg;

   localparam int EXC_W = 13;

   // Bit order is also the in-lane priority order (bit 0 highest).
   typedef enum logic [3:0] {
      IADDR_ALIGN = 4'd0,
      ITLB_REFILL = 4'd1,
      ITLB_INV    = 4'd2,
      SYSCALL     = 4'd3,
      BREAK       = 4'd4,
      RI          = 4'd5,
      CPU         = 4'd6,
      OV          = 4'd7,
      ERET        = 4'd8,
      DADDR_ALIGN = 4'd9,
      DTLB_REFILL = 4'd10,
      DTLB_INV    = 4'd11,
      DTLB_MOD    = 4'd12
   } exc_cause_e;

   localparam logic [4:0] CODE_INT  = 5'h00;
   localparam logic [4:0] CODE_MOD  = 5'h01;
   localparam logic [4:0] CODE_TLBL = 5'h02;
   localparam logic [4:0] CODE_TLBS = 5'h03;
   localparam logic [4:0] CODE_ADEL = 5'h04;
   localparam logic [4:0] CODE_ADES = 5'h05;
   localparam logic [4:0] CODE_SYS  = 5'h08;
   localparam logic [4:0] CODE_BP   = 5'h09;
   localparam logic [4:0] CODE_RI   = 5'h0a;
   localparam logic [4:0] CODE_CPU  = 5'h0b;
   localparam logic [4:0] CODE_OV   = 5'h0c;

   localparam logic [31:0] OFF_REFILL   = 32'h0000_0000;
   localparam logic [31:0] OFF_GENERAL  = 32'h0000_0180;
   localparam logic [31:0] OFF_INT_IV   = 32'h0000_0200;
   localparam logic [31:0] BOOTSTRAP_BASE = 32'hbfc0_0200;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COMMIT   = 2'd1,
      ST_REDIRECT = 2'd2
   } exc_state_e;

endpackage

`default_nettype wire

// File: rtl/exception_beta_lane_decode.sv
// exc_lane_decode: combinational per-lane ExcCode, BadVAddr and handler-offset
// generator; a pending interrupt (lane 0 only) overrides all synchronous causes.
`default_nettype none

module exc_lane_decode
   import exception_pkg::*;
(
   input  logic             valid,
   input  logic [EXC_W-1:0] cause,
   input  logic [31:0]      pc,
   input  logic [31:0]      mem_addr,
   input  logic             mem_wen,
   input  logic             bd,
   input  logic             int_pending,
   input  logic             exl_set,
   input  logic             use_special_iv,
   output logic             hit,
   output logic             is_eret,
   output logic [4:0]       code,
   output logic [31:0]      offset,
   output logic [31:0]      epc,
   output logic [31:0]      bad_vaddr,
   output logic             bad_vaddr_wen
);

   logic [31:0] refill_off;

   assign hit        = valid & (int_pending | (|cause));
   assign epc        = bd ? (pc - 32'd4) : pc;
   assign refill_off = exl_set ? OFF_GENERAL : OFF_REFILL;

   always_comb begin
      code          = CODE_INT;
      offset        = OFF_GENERAL;
      bad_vaddr     = 32'h0;
      bad_vaddr_wen = 1'b0;
      is_eret       = 1'b0;
      if (int_pending) begin
         offset = use_special_iv ? OFF_INT_IV : OFF_GENERAL;
      end else if (cause[IADDR_ALIGN]) begin
         code = CODE_ADEL; bad_vaddr = pc; bad_vaddr_wen = 1'b1;
      end else if (cause[ITLB_REFILL]) begin
         code = CODE_TLBL; bad_vaddr = pc; bad_vaddr_wen = 1'b1; offset = refill_off;
      end else if (cause[ITLB_INV]) begin
         code = CODE_TLBL; bad_vaddr = pc; bad_vaddr_wen = 1'b1;
      end else if (cause[SYSCALL]) begin
         code = CODE_SYS;
      end else if (cause[BREAK]) begin
         code = CODE_BP;
      end else if (cause[RI]) begin
         code = CODE_RI;
      end else if (cause[CPU]) begin
         code = CODE_CPU;
      end else if (cause[OV]) begin
         code = CODE_OV;
      end else if (cause[ERET]) begin
         is_eret = 1'b1;
      end else if (cause[DADDR_ALIGN]) begin
         code = mem_wen ? CODE_ADES : CODE_ADEL; bad_vaddr = mem_addr; bad_vaddr_wen = 1'b1;
      end else if (cause[DTLB_REFILL]) begin
         code = mem_wen ? CODE_TLBS : CODE_TLBL; bad_vaddr = mem_addr; bad_vaddr_wen = 1'b1;
         offset = refill_off;
      end else if (cause[DTLB_INV]) begin
         code = mem_wen ? CODE_TLBS : CODE_TLBL; bad_vaddr = mem_addr; bad_vaddr_wen = 1'b1;
      end else if (cause[DTLB_MOD]) begin
         code = CODE_MOD; bad_vaddr = mem_addr; bad_vaddr_wen = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/exception_beta.sv
// exception_beta: oldest-lane exception arbiter with CP0 commit and fetch-redirect
// handshake. Define EXC_STATS_EN to add the exp_count / last_code statistics ports.
`default_nettype none

module exception_beta
   import exception_pkg::*;
#(
   parameter int LANES       = 2,
   parameter int NUM_INT     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [LANES-1:0]         lane_valid,
   input  logic [LANES*EXC_W-1:0]   lane_cause,
   input  logic [LANES*32-1:0]      lane_pc,
   input  logic [LANES-1:0]         lane_bd,
   input  logic [LANES*32-1:0]      lane_mem_addr,
   input  logic [LANES-1:0]         lane_mem_wen,
   input  logic [NUM_INT-1:0]       int_raw,
   input  logic [NUM_INT-1:0]       int_mask,
   input  logic                     allow_interrupt,
   input  logic                     exl_set,
   input  logic [31:0]              epc_in,
   input  logic [31:0]              cp0_ebase,
   input  logic                     cp0_use_bootstrap_iv,
   input  logic                     cp0_use_special_iv,
   input  logic                     redirect_ready,
   output logic                     busy,
   output logic                     flush,
   output logic [LANES-1:0]         kill_mask,
   output logic                     cp0_exp_en,
   output logic                     cp0_exl_clean,
   output logic [4:0]               cp0_exp_code,
   output logic [31:0]              cp0_exp_epc,
   output logic                     cp0_exp_bd,
   output logic [31:0]              cp0_exp_bad_vaddr,
   output logic                     cp0_exp_bad_vaddr_wen,
   output logic [$clog2(LANES)-1:0] exp_lane,
   output logic                     redirect_valid,
   output logic [31:0]              redirect_pc
`ifdef EXC_STATS_EN
   ,
   output logic [31:0]              exp_count,
   output logic [4:0]               last_code
`endif
);

   localparam int LANE_W = $clog2(LANES);

   exc_state_e state, state_next;

   logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
   logic [NUM_INT-1:0] int_sync;
   logic               int_pend;

   logic [LANES-1:0] hit, is_eret, bvwen;
   logic [4:0]       code [LANES];
   logic [31:0]      off [LANES];
   logic [31:0]      epc [LANES];
   logic [31:0]      bv  [LANES];

   logic              found;
   logic [LANE_W-1:0] win;
   logic [LANES-1:0]  kill_d;
   logic [31:0]       vec_base;
   logic              capture;

   logic [LANES-1:0] kill_q;
   logic             eret_q;

   logic unused_ebase;
   assign unused_ebase = ^{cp0_ebase[31:30], cp0_ebase[11:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= int_raw;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign int_sync = sync_q[SYNC_STAGES-1];
   assign int_pend = (|(int_sync & int_mask)) & allow_interrupt & lane_valid[0];

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      exc_lane_decode u_dec (
         .valid          (lane_valid[g]),
         .cause          (lane_cause[g*EXC_W +: EXC_W]),
         .pc             (lane_pc[g*32 +: 32]),
         .mem_addr       (lane_mem_addr[g*32 +: 32]),
         .mem_wen        (lane_mem_wen[g]),
         .bd             (lane_bd[g]),
         .int_pending    ((g == 0) ? int_pend : 1'b0),
         .exl_set        (exl_set),
         .use_special_iv (cp0_use_special_iv),
         .hit            (hit[g]),
         .is_eret        (is_eret[g]),
         .code           (code[g]),
         .offset         (off[g]),
         .epc            (epc[g]),
         .bad_vaddr      (bv[g]),
         .bad_vaddr_wen  (bvwen[g])
      );
   end

   // Scan from youngest to oldest so the oldest hit is what remains.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            found = 1'b1;
            win   = LANE_W'(i);
         end
      end
      kill_d = '0;
      for (int i = 0; i < LANES; i++) kill_d[i] = (i >= int'(win));
   end

   assign vec_base = cp0_use_bootstrap_iv ? BOOTSTRAP_BASE
                                          : {2'b10, cp0_ebase[29:12], 12'h000};
   assign capture  = (state == ST_IDLE) && found;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next     = state;
      busy           = 1'b0;
      flush          = 1'b0;
      kill_mask      = '0;
      cp0_exp_en     = 1'b0;
      cp0_exl_clean  = 1'b0;
      redirect_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            if (found) state_next = ST_COMMIT;
         end
         ST_COMMIT: begin
            busy          = 1'b1;
            flush         = 1'b1;
            kill_mask     = kill_q;
            cp0_exp_en    = ~eret_q;
            cp0_exl_clean = eret_q;
            state_next    = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            busy           = 1'b1;
            redirect_valid = 1'b1;
            if (redirect_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kill_q                <= '0;
         eret_q                <= 1'b0;
         cp0_exp_code          <= 5'h0;
         cp0_exp_epc           <= 32'h0;
         cp0_exp_bd            <= 1'b0;
         cp0_exp_bad_vaddr     <= 32'h0;
         cp0_exp_bad_vaddr_wen <= 1'b0;
         exp_lane              <= '0;
         redirect_pc           <= 32'h0;
      end else if (capture) begin
         kill_q                <= kill_d;
         eret_q                <= is_eret[win];
         cp0_exp_code          <= code[win];
         cp0_exp_epc           <= epc[win];
         cp0_exp_bd            <= lane_bd[win];
         cp0_exp_bad_vaddr     <= bv[win];
         cp0_exp_bad_vaddr_wen <= bvwen[win];
         exp_lane              <= win;
         redirect_pc           <= is_eret[win] ? epc_in : (vec_base + off[win]);
      end
   end

`ifdef EXC_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_count <= 32'h0;
         last_code <= 5'h0;
      end else if (state == ST_COMMIT && !eret_q) begin
         exp_count <= exp_count + 32'd1;
         last_code <= cp0_exp_code;
      end
   end
`endif

endmodule

`default_nettype wire
